// File: rtl/bls_option_feeder.sv
// Option parameter feeder for the Black-Scholes lanes: streams NUM_FIELDS-word records
// from the parameter RAM into per-lane holding registers under a round-robin grant.
module bls_option_feeder #(
  parameter int BSMODS     = 1,
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 5,
  parameter int CNT_W      = 10,
  parameter int MEM_AW     = 13
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                startBatch,
  input  logic [CNT_W-1:0]                    numOptions,
  input  logic [BSMODS-1:0]                   SERVE_REG,
  input  logic [BSMODS-1:0]                   BS_START,
  input  logic [DATA_W-1:0]                   mem_rdata,
  output logic                                mem_en,
  output logic [MEM_AW-1:0]                   mem_addr,
  output logic [BSMODS-1:0]                   hasUnusedData,
  output logic                                OutOfData,
  output logic [BSMODS*NUM_FIELDS*DATA_W-1:0] opt_data,
  output logic [BSMODS*CNT_W-1:0]             opt_index
);

  localparam int LANE_W = (BSMODS > 1) ? $clog2(BSMODS) : 1;
  localparam int FLD_W  = $clog2(NUM_FIELDS + 1);
  localparam logic [FLD_W-1:0] LAST_FLD = FLD_W'(NUM_FIELDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    FETCH   = 2'd2,
    DRAINED = 2'd3
  } state_t;

  state_t                           state_r, state_s;
  logic [FLD_W-1:0]                 fcnt_r, fcnt_s;
  logic [CNT_W-1:0]                 count_r, ptr_r;
  logic [MEM_AW-1:0]                base_r;
  logic [LANE_W-1:0]                rr_r, grant_r, pick_s, rr_s;
  logic [BSMODS-1:0]                elig_s, rot_s, set_s;
  logic                             found_s;
  logic                             start_s, grant_s, drain_s, finish_s;
  logic                             mem_en_s;
  logic [MEM_AW-1:0]                mem_addr_s;
  logic                             mem_en_r;
  logic [MEM_AW-1:0]                mem_addr_r;
  logic [BSMODS-1:0]                unused_r;
  logic                             ood_r;
  logic [BSMODS*NUM_FIELDS*DATA_W-1:0] data_r;
  logic [BSMODS*CNT_W-1:0]          index_r;

  // Round-robin pick: rotate the eligible mask so bit 0 is the rr pointer, take the first hit.
  always_comb begin
    elig_s  = SERVE_REG & ~unused_r;
    rot_s   = BSMODS'({elig_s, elig_s} >> rr_r);
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < BSMODS; i++) begin
      pick_s  = (!found_s && rot_s[i]) ? LANE_W'((int'(rr_r) + i) % BSMODS) : pick_s;
      found_s = found_s | rot_s[i];
    end
    rr_s = (pick_s == LANE_W'(BSMODS - 1)) ? '0 : pick_s + LANE_W'(1);
  end

  // Next-state decode plus the RAM request for the coming cycle.
  always_comb begin
    state_s  = state_r;
    fcnt_s   = fcnt_r;
    start_s  = 1'b0;
    grant_s  = 1'b0;
    drain_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE, DRAINED: begin
        if (startBatch) begin
          start_s = 1'b1;
          state_s = ARB;
          fcnt_s  = '0;
        end else begin
          state_s = state_r;
        end
      end
      ARB: begin
        if (ptr_r == count_r) begin
          drain_s = 1'b1;
          state_s = DRAINED;
        end else if (found_s) begin
          grant_s = 1'b1;
          state_s = FETCH;
          fcnt_s  = '0;
        end else begin
          state_s = ARB;
        end
      end
      FETCH: begin
        if (fcnt_r == LAST_FLD) begin
          finish_s = 1'b1;
          state_s  = ARB;
          fcnt_s   = '0;
        end else begin
          fcnt_s = fcnt_r + FLD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        fcnt_s  = '0;
      end
    endcase
    // base_r only moves on the finishing edge, when no read is being requested.
    mem_en_s   = (state_s == FETCH) && (fcnt_s < LAST_FLD);
    mem_addr_s = mem_en_s ? (base_r + MEM_AW'(fcnt_s)) : '0;
    set_s      = finish_s ? (BSMODS'(1) << grant_r) : '0;
  end

  // FSM state and field counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      fcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
    end
  end

  // Batch bookkeeping, RAM port, lane flags and lane holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r    <= '0;
      ptr_r      <= '0;
      base_r     <= '0;
      rr_r       <= '0;
      grant_r    <= '0;
      mem_en_r   <= 1'b0;
      mem_addr_r <= '0;
      unused_r   <= '0;
      ood_r      <= 1'b0;
      data_r     <= '0;
      index_r    <= '0;
    end else begin
      mem_en_r   <= mem_en_s;
      mem_addr_r <= mem_addr_s;
      if (start_s) begin
        count_r <= numOptions;
        ptr_r   <= '0;
        base_r  <= '0;
        ood_r   <= 1'b0;
      end
      if (drain_s) begin
        ood_r <= 1'b1;
      end
      if (grant_s) begin
        grant_r <= pick_s;
        rr_r    <= rr_s;
      end
      if (finish_s) begin
        ptr_r  <= ptr_r + CNT_W'(1);
        base_r <= base_r + MEM_AW'(NUM_FIELDS);
      end
      // A consume strobe in the same cycle as a load beats the load.
      unused_r <= (unused_r | set_s) & ~BS_START;
      for (int l = 0; l < BSMODS; l++) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          if (state_r == FETCH && grant_r == LANE_W'(l) && fcnt_r == FLD_W'(f + 1)) begin
            data_r[(l*NUM_FIELDS+f)*DATA_W +: DATA_W] <= mem_rdata;
          end
        end
        if (finish_s && grant_r == LANE_W'(l)) begin
          index_r[l*CNT_W +: CNT_W] <= ptr_r;
        end
      end
    end
  end

  assign mem_en        = mem_en_r;
  assign mem_addr      = mem_addr_r;
  assign hasUnusedData = unused_r;
  assign OutOfData     = ood_r;
  assign opt_data      = data_r;
  assign opt_index     = index_r;

endmodule
